// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode/direction encodings, initial LED patterns and ms-to-cycles helper
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK_ALL = 2'd0,
        MODE_BIN_COUNT = 2'd1,
        MODE_RUN_LIGHT = 2'd2,
        MODE_BOUNCE    = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [3:0] INIT_BLINK_ALL = 4'b0000;
    localparam logic [3:0] INIT_BIN_COUNT = 4'b0000;
    localparam logic [3:0] INIT_RUN_LIGHT = 4'b0001;
    localparam logic [3:0] INIT_BOUNCE    = 4'b0001;

    function automatic int unsigned cycles_from_ms(int unsigned freq_hz, int unsigned ms);
        return freq_hz / 1000 * ms;
    endfunction

    function automatic logic [3:0] init_pattern(mode_t m);
        return (m == MODE_BLINK_ALL) ? INIT_BLINK_ALL :
               (m == MODE_BIN_COUNT) ? INIT_BIN_COUNT :
               (m == MODE_RUN_LIGHT) ? INIT_RUN_LIGHT : INIT_BOUNCE;
    endfunction

endpackage

// File: rtl/led_btn_debounce.sv
// led_btn_debounce: 2-FF synchronizer, stability counter and one-cycle pulse on a debounced press
// Button is active-low; the pulse fires the cycle after the debounced level falls.
module led_btn_debounce #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic req
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn_n};
            level_q <= level;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

    assign req = level_q & ~level;

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: prescaled 4-LED pattern generator with mode cycling.
// Define BUTTON_DEBOUNCE_EN to take mode_btn_i from a raw active-low button via led_btn_debounce.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 33_333_333,
    parameter int unsigned STEP_MS     = 250,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       mode_btn_i,
    input  logic       pause_i,
    output logic [3:0] leds_o,
    output logic [1:0] mode_o,
    output logic       tick_o
);
    localparam int unsigned STEP_CYCLES = cycles_from_ms(CLK_FREQ_HZ, STEP_MS);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    if (STEP_CYCLES < 2) begin : g_step_check
        $error("led_pattern_sequencer: STEP_CYCLES must be at least 2");
    end

    logic mode_req;

`ifdef BUTTON_DEBOUNCE_EN
    led_btn_debounce #(
        .CYCLES(cycles_from_ms(CLK_FREQ_HZ, DEBOUNCE_MS))
    ) u_debounce (
        .clk  (clk_i),
        .rst_n(rst_n_i),
        .btn_n(mode_btn_i),
        .req  (mode_req)
    );
`else
    assign mode_req = mode_btn_i;
`endif

    mode_t         mode, mode_nxt;
    dir_t          dir, dir_nxt;
    logic [3:0]    leds, leds_nxt, step_leds;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tick, tick_nxt;
    logic          wrap;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mode <= MODE_BLINK_ALL;
            dir  <= DIR_UP;
            leds <= '0;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            mode <= mode_nxt;
            dir  <= dir_nxt;
            leds <= leds_nxt;
            cnt  <= cnt_nxt;
            tick <= tick_nxt;
        end
    end

    // Bounce flips direction on the step that lands on an endpoint, so endpoints are never held twice.
    always_comb begin
        mode_nxt  = mode;
        dir_nxt   = dir;
        leds_nxt  = leds;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        wrap      = (cnt == LAST);
        step_leds = (mode == MODE_BLINK_ALL) ? ~leds :
                    (mode == MODE_BIN_COUNT) ? leds + 4'd1 :
                    (mode == MODE_RUN_LIGHT) ? {leds[2:0], leds[3]} :
                    (dir == DIR_UP)          ? leds << 1 : leds >> 1;
        if (mode_req) begin
            mode_nxt = mode_t'(mode + 2'd1);
            leds_nxt = init_pattern(mode_nxt);
            dir_nxt  = DIR_UP;
            cnt_nxt  = '0;
        end else if (!pause_i) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                tick_nxt = 1'b1;
                leds_nxt = step_leds;
                if (mode == MODE_BOUNCE)
                    dir_nxt = (step_leds == 4'b1000) ? DIR_DOWN :
                              (step_leds == 4'b0001) ? DIR_UP : dir;
            end
        end
    end

    assign leds_o = leds;
    assign mode_o = mode;
    assign tick_o = tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed checks of reset, stepping, bounce, mode collision, pause and reset mid-pattern.
// With BUTTON_DEBOUNCE_EN defined, reset and the glitch/press debounce scenario are exercised instead.
module tb_led_pattern_sequencer;

`ifdef BUTTON_DEBOUNCE_EN
    localparam logic BTN_IDLE = 1'b1;
`else
    localparam logic BTN_IDLE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_btn;
    logic       pause;
    logic [3:0] leds;
    logic [1:0] mode;
    logic       tick;
    int         tests = 0;
    int         fails = 0;

    led_pattern_sequencer #(
        .CLK_FREQ_HZ(4000),
        .STEP_MS    (1),
        .DEBOUNCE_MS(2)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .mode_btn_i(mode_btn),
        .pause_i   (pause),
        .leds_o    (leds),
        .mode_o    (mode),
        .tick_o    (tick)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        mode_btn = BTN_IDLE;
        pause = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (mode !== 2'd0 || leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: mode=%0d leds=%b tick=%b, want 0 0000 0", mode, leds, tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (mode !== 2'd0 || leds !== 4'b0000) begin
            fails++;
            $display("FAIL reset_release: mode=%0d leds=%b, want 0 0000", mode, leds);
        end
    endtask

`ifndef BUTTON_DEBOUNCE_EN
    task automatic test_bin_count;
        logic [3:0] exp_leds;
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
        tests++;
        if (mode !== 2'd1 || leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL bin_select: mode=%0d leds=%b tick=%b, want 1 0000 0", mode, leds, tick);
        end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            exp_leds = 4'((i / 4) % 16);
            tests++;
            if (tick !== (i % 4 == 0) || leds !== exp_leds) begin
                fails++;
                $display("FAIL bin_step cycle %0d: tick=%b leds=%b, want %b %b", i, tick, leds, (i % 4 == 0), exp_leds);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        mode_btn = 1'b1;
        repeat (2) @(negedge clk);
        mode_btn = 1'b0;
        tests++;
        if (mode !== 2'd3 || leds !== 4'b0001) begin
            fails++;
            $display("FAIL bounce_select: mode=%0d leds=%b, want 3 0001", mode, leds);
        end
        for (int s = 0; s < 8; s++) begin
            repeat (4) @(negedge clk);
            tests++;
            if (tick !== 1'b1 || leds !== exp_seq[s]) begin
                fails++;
                $display("FAIL bounce_step %0d: tick=%b leds=%b, want 1 %b", s, tick, leds, exp_seq[s]);
            end
        end
    endtask

    task automatic test_mode_collision;
        repeat (3) @(negedge clk);
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
        tests++;
        if (mode !== 2'd0 || leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL collision: mode=%0d leds=%b tick=%b, want 0 0000 0", mode, leds, tick);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests++;
            if (tick !== (i == 4) || leds !== ((i == 4) ? 4'b1111 : 4'b0000)) begin
                fails++;
                $display("FAIL collision_next cycle %0d: tick=%b leds=%b, want %b %b", i, tick, leds, (i == 4), (i == 4) ? 4'b1111 : 4'b0000);
            end
        end
    endtask

    task automatic test_pause;
        mode_btn = 1'b1;
        repeat (2) @(negedge clk);
        mode_btn = 1'b0;
        tests++;
        if (mode !== 2'd2 || leds !== 4'b0001) begin
            fails++;
            $display("FAIL run_select: mode=%0d leds=%b, want 2 0001", mode, leds);
        end
        repeat (2) @(negedge clk);
        pause = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tests++;
            if (tick !== 1'b0 || leds !== 4'b0001) begin
                fails++;
                $display("FAIL pause_hold cycle %0d: tick=%b leds=%b, want 0 0001", i, tick, leds);
            end
        end
        pause = 1'b0;
        @(negedge clk);
        tests++;
        if (tick !== 1'b0 || leds !== 4'b0001) begin
            fails++;
            $display("FAIL pause_resume1: tick=%b leds=%b, want 0 0001", tick, leds);
        end
        @(negedge clk);
        tests++;
        if (tick !== 1'b1 || leds !== 4'b0010) begin
            fails++;
            $display("FAIL pause_resume2: tick=%b leds=%b, want 1 0010", tick, leds);
        end
    endtask

    task automatic test_reset_mid_pattern;
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
        repeat (12) @(negedge clk);
        tests++;
        if (mode !== 2'd3 || leds !== 4'b1000) begin
            fails++;
            $display("FAIL mid_setup: mode=%0d leds=%b, want 3 1000", mode, leds);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (mode !== 2'd0 || leds !== 4'b0000 || tick !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: mode=%0d leds=%b tick=%b, want 0 0000 0", mode, leds, tick);
        end
        mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        mode_btn = 1'b0;
        tests++;
        if (mode !== 2'd3 || leds !== 4'b0001) begin
            fails++;
            $display("FAIL mid_reselect: mode=%0d leds=%b, want 3 0001", mode, leds);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (leds !== 4'b0010) begin
            fails++;
            $display("FAIL mid_up1: leds=%b, want 0010", leds);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (leds !== 4'b0100) begin
            fails++;
            $display("FAIL mid_up2: leds=%b, want 0100", leds);
        end
    endtask
`else
    task automatic test_debounce;
        int lat;
        mode_btn = 1'b0;
        repeat (5) @(negedge clk);
        mode_btn = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (mode !== 2'd0) begin
            fails++;
            $display("FAIL glitch: mode=%0d, want 0", mode);
        end
        lat = 0;
        mode_btn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat == 0 && mode == 2'd1) lat = i;
        end
        mode_btn = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (lat != 11) begin
            fails++;
            $display("FAIL press_latency: got %0d cycles, want 11", lat);
        end
        tests++;
        if (mode !== 2'd1) begin
            fails++;
            $display("FAIL press_once: mode=%0d, want 1", mode);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef BUTTON_DEBOUNCE_EN
        test_bin_count();
        test_bounce();
        test_mode_collision();
        test_pause();
        test_reset_mid_pattern();
`else
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
